// File: rtl/bit_serializer.sv
// Parallel-in/serial-out stage feeding the serial sequence detector.
// Accepts WIDTH-bit words on a valid/ready handshake and emits one bit per clk
// with a dvalid qualifier, a last-bit marker and a busy flag.
// Optional feature: define SER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pdata,
  input  logic             pvalid,
  output logic             pready,
  output logic             dout,
  output logic             dvalid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             dout_q;
  logic             dvalid_q;
  logic             last_q;
  logic             busy_q;
`ifdef SER_PARITY_EN
  logic             parity_q;
`endif

  logic             at_last_data;
  logic             xfer;
  logic [CNT_W-1:0] cnt_inc;

  // Bit that goes out next from a word, in the configured order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word with its head bit consumed, remaining bits moved toward the head.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Handshake: ready while idle or while the final bit of a word is on dout.
  assign at_last_data = (state_q == ST_SHIFT) && (bit_cnt_q == CNT_LAST);
`ifdef SER_PARITY_EN
  assign pready = (state_q == ST_IDLE) || (state_q == ST_PARITY);
`else
  assign pready = (state_q == ST_IDLE) || at_last_data;
`endif
  assign xfer    = pvalid && pready;
  assign cnt_inc = bit_cnt_q + CNT_W'(1);

  // State, shift register and registered serial outputs; reset beats a same-cycle transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      dout_q    <= 1'b0;
      dvalid_q  <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else if (xfer) begin
      // Load: first bit appears on dout in the cycle right after the accept edge.
      state_q   <= ST_SHIFT;
      shreg_q   <= advance(pdata);
      bit_cnt_q <= '0;
      dout_q    <= head_bit(pdata);
      dvalid_q  <= 1'b1;
      last_q    <= 1'b0;
      busy_q    <= 1'b1;
`ifdef SER_PARITY_EN
      parity_q  <= ^pdata;
`endif
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (bit_cnt_q != CNT_LAST) begin
            bit_cnt_q <= cnt_inc;
            shreg_q   <= advance(shreg_q);
            dout_q    <= head_bit(shreg_q);
`ifdef SER_PARITY_EN
            last_q    <= 1'b0;
`else
            last_q    <= (cnt_inc == CNT_LAST);
`endif
          end else begin
`ifdef SER_PARITY_EN
            // Final data bit done; the parity bit closes the word.
            state_q   <= ST_PARITY;
            dout_q    <= parity_q;
            last_q    <= 1'b1;
`else
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            dout_q    <= 1'b0;
            dvalid_q  <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
`endif
          end
        end
        default: begin
          // Idle (or parity done): hold a clean zero stream downstream.
          state_q   <= ST_IDLE;
          bit_cnt_q <= '0;
          dout_q    <= 1'b0;
          dvalid_q  <= 1'b0;
          last_q    <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign last   = last_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share the stimulus and
// are compared every cycle against a queue-of-pending-bits reference model.
module tb_bit_serializer;

  localparam int unsigned W = 8;
`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic m;    // bit expected from the MSB-first instance
    logic l;    // bit expected from the LSB-first instance
    logic lst;  // last marker
  } exp_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] pdata;
  logic         pvalid;
  logic         pready_m, dout_m, dvalid_m, last_m, busy_m;
  logic         pready_l, dout_l, dvalid_l, last_l, busy_l;

  int   checks;
  int   failures;
  exp_t q[$];

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .pdata(pdata), .pvalid(pvalid), .pready(pready_m),
    .dout(dout_m), .dvalid(dvalid_m), .last(last_m), .busy(busy_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .pdata(pdata), .pvalid(pvalid), .pready(pready_l),
    .dout(dout_l), .dvalid(dvalid_l), .last(last_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs: the head of the pending-bit queue, or a quiet line when empty.
  task automatic check_outputs();
    exp_t e;
    logic act;
    act = (q.size() != 0);
    e   = act ? q[0] : '0;
    chk("dout_msb",   dout_m,   e.m);
    chk("dout_lsb",   dout_l,   e.l);
    chk("dvalid_msb", dvalid_m, act);
    chk("dvalid_lsb", dvalid_l, act);
    chk("last_msb",   last_m,   e.lst);
    chk("last_lsb",   last_l,   e.lst);
    chk("busy_msb",   busy_m,   act);
    chk("busy_lsb",   busy_l,   act);
  endtask

  task automatic push_word(input logic [W-1:0] d);
    exp_t e;
    for (int i = 0; i < int'(W); i++) begin
      e.m   = d[W-1-i];
      e.l   = d[i];
      e.lst = (i == int'(W) - 1) && !PAR;
      q.push_back(e);
    end
    if (PAR) begin
      e.m   = ^d;
      e.l   = ^d;
      e.lst = 1'b1;
      q.push_back(e);
    end
  endtask

  // One clock: drive inputs, check pready, advance the model, check registered outputs.
  task automatic step(input logic rst, input logic v, input logic [W-1:0] d);
    logic rdy_exp;
    logic xfer;
    reset   = rst;
    pvalid  = v;
    pdata   = d;
    rdy_exp = (q.size() <= 1);
    chk("pready_msb", pready_m, rdy_exp);
    chk("pready_lsb", pready_l, rdy_exp);
    xfer = v && rdy_exp;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() != 0) void'(q.pop_front());
      if (xfer) push_word(d);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    pvalid   = 1'b1;
    pdata    = 8'hA5;

    // Reset held two clocks with a pending transfer: reset must win.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    chk("pready_rst_msb", pready_m, 1'b1);
    chk("pready_rst_lsb", pready_l, 1'b1);
    step(1'b1, 1'b1, 8'h3C);

    // Single word, then drain to idle.
    step(1'b0, 1'b1, 8'hD0);
    idle(W + 3);

    // Back-to-back words with pvalid held high.
    step(1'b0, 1'b1, 8'hD0);
    for (int i = 0; i < int'(W) + int'(PAR); i++) step(1'b0, 1'b1, 8'h0D);
    idle(W + 3);

    // LSB-first pattern word.
    step(1'b0, 1'b1, 8'h0B);
    idle(W + 3);

    // Reset on the fourth bit of 8'hFF, then a fresh word.
    step(1'b0, 1'b1, 8'hFF);
    idle(3);
    step(1'b1, 1'b1, 8'h55);
    step(1'b0, 1'b1, 8'h96);
    idle(W + 3);

    // Parity contrast words (odd and even population).
    step(1'b0, 1'b1, 8'hD0);
    idle(W + 2);
    step(1'b0, 1'b1, 8'hC0);
    idle(W + 2);

    // Random traffic with sparse resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), W'($urandom));
    end
    idle(W + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
